data_inf_rr_arbiter: RTL and testbench
======================================

# data_inf_rr_arbiter

- **Purpose:** shares one downstream `data_inf_c`-style stream (data/valid/ready) between NUM upstream requesters.
- **Policy:** round-robin, with a per-grant burst limit.
- **Output:** a registered single-entry stage drives the shared sink.
- **Placement:** sits in front of shared datapath consumers, e.g. one `c_inf` lane fed by several producers.

## Interface

Parameters:
- `NUM`, 4 — number of requesters (≥1).
- `DSIZE`, 18 — data width.
- `BURST`, 8 — maximum beats accepted per grant (≥1).

Ports:
- `clock`  in  1 — sole clock.
- `rst_n`  in  1 — reset, asynchronous, active-low.
- `s_data`  in  NUM×DSIZE — requester data, unpacked `[NUM-1:0]`.
- `s_valid`  in  NUM — requester valid.
- `s_ready`  out  NUM — requester ready.
- `m_data`  out  DSIZE — shared stream data (registered).
- `m_valid`  out  1 — shared stream valid (registered).
- `m_ready`  in  1 — shared stream ready.
- `curr_grant`  out  GW — index of the granted requester; GW = max(1, $clog2(NUM)).
- `busy`  out  1 — high while in GRANT.
- `grant_cnt`  out  NUM×16 — only with `DATA_INF_RR_ARB_STAT_EN`; see Configuration.

## Operation

- **States:** IDLE, GRANT.
- **IDLE:**
  - If any `s_valid` is high, pick the first requester with valid set, searching from `last_grant+1` upward with wrap at NUM.
  - Register it into `curr_grant` and `last_grant`, clear `beat_cnt`, and go to GRANT.
  - If no `s_valid` is high, stay in IDLE.
- **GRANT:**
  - `s_ready[curr_grant] = (!m_valid || m_ready)`; all other `s_ready` bits are 0.
  - A beat is accepted when `s_valid & s_ready` for the granted index. Acceptance loads `m_data` and sets `m_valid`, and increments `beat_cnt`.
- **Output register:**
  - Clears `m_valid` on `m_valid & m_ready` when no new beat is loaded.
  - Load and drain in the same cycle keeps `m_valid`=1 with the new data.
- **Release conditions** (any one) move the state to IDLE next cycle:
  - (a) The beat accepted this cycle makes `beat_cnt` == BURST.
  - (b) `s_valid[curr_grant]`=0 while its `s_ready` would be 1.
- **Stall:** while the output is stalled (`m_valid & !m_ready`), a low `s_valid` does not release the grant.
- **Burst counter:** width $clog2(BURST+1); it never exceeds BURST.
- **Data:** passes unmodified; no width conversion.
- **NUM=1:** the arbiter degenerates to a burst-gapped register slice.

## Timing

- **Reset values:**
  - `m_valid`=0, `m_data`=0, `s_ready`=0, `curr_grant`=0, `busy`=0.
  - Internal: state=IDLE, `last_grant`=NUM-1 (requester 0 wins first), `beat_cnt`=0.
- **Grant latency:** `s_valid` rising in IDLE at cycle 0 → GRANT and `s_ready` high at cycle 1 → first beat on `m_data`/`m_valid` at cycle 2.
- **Throughput:** 1 beat/cycle within a grant when `m_ready`=1.
- **Re-arbitration:** every grant change costs exactly one IDLE cycle with all `s_ready`=0. Peak utilisation is BURST/(BURST+1).
- **Output during re-arbitration:** the output register continues to drain during IDLE.
- **Combinational paths:** `s_ready` depends combinationally on `m_ready`. `m_valid` and `m_data` are purely registered.
- **Reset mid-burst:**
  - The held `m_data` beat is discarded and `m_valid` drops immediately (asynchronous).
  - After reset, arbitration restarts from requester 0.

## Configuration

- **`DATA_INF_RR_ARB_STAT_EN` defined:**
  - Adds `grant_cnt`: per-requester 16-bit counters, incremented on each IDLE→GRANT transition for that index.
  - Counters wrap 0xFFFF→0 and reset to 0.
- **Undefined:** the port and counters are absent; all other behaviour is identical.

## Structure

- **Package `data_inf_arb_pkg`:**
  - Typedef `arb_state_e` {IDLE, GRANT}.
  - Constant `STAT_W` = 16.
  - Function `rr_next(req, last)` returning the next index.
- **Sub-module `data_inf_rr_pick`:**
  - Combinational rotate/priority-encode of `s_valid` from `last_grant+1`.
  - Outputs `pick_idx` and `pick_vld`.
  - The top level holds the FSM, burst counter, output register and optional statistics.

## Test plan

- **Single requester:** NUM=4, BURST=8, `m_ready`=1, only requester 2 valid with data 0x10..0x1F.
  - Grant at cycle 1, first beat at cycle 2.
  - `s_ready[2]` drops after 8 beats for one IDLE cycle.
  - Then re-grant to 2; all 16 beats arrive in order.
- **Fairness:** all 4 requesters valid continuously, BURST=2.
  - `curr_grant` sequence 0,1,2,3,0.
  - Each grant yields exactly 2 beats separated by one IDLE cycle.
- **Backpressure:** `m_ready`=0 for 5 cycles mid-burst.
  - `m_valid`/`m_data` hold the same value.
  - `s_ready`=0 and no beat is lost or duplicated.
  - `s_valid` dropping during the stall does not release the grant.
- **Early release:** requester 1 presents 3 beats with BURST=8, then drops `s_valid`.
  - Grant releases the next cycle.
  - Pending requester 3 is granted after one IDLE cycle.
- **Reset mid-burst:** assert `rst_n`=0 with `m_valid`=1.
  - All outputs reset immediately.
  - After release with all requesters valid, requester 0 is granted first.
- **Statistics** (`DATA_INF_RR_ARB_STAT_EN` defined): run the fairness scenario for 8 grants → `grant_cnt` = {2,2,2,2}.

Source files
------------

// File: rtl/data_inf_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package data_inf_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int STAT_W  = 16;
   // Widest requester vector rr_next can search (index fits in 5 bits).
   localparam int MAX_REQ = 32;

   // Next requester with its bit set in req, searching from last+1 upward
   // and wrapping at num. Returns last when nothing is requesting.
   function automatic int rr_next(input logic [MAX_REQ-1:0] req,
                                  input int                 last,
                                  input int                 num);
      int res;
      int idx;
      res = last;
      idx = 0;
      // Walk the largest offset first so the nearest requester wins.
      for (int k = MAX_REQ; k >= 1; k--) begin
         if (k <= num) begin
            idx = (last + k) % num;
            if (req[idx[4:0]]) begin
               res = idx;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/data_inf_rr_pick.sv
// Round-robin pick: first valid requester after last_grant, wrapping at NUM.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is registered.
module data_inf_rr_pick
   import data_inf_arb_pkg::*;
#(
   parameter  int NUM = 4,
   localparam int GW  = (NUM > 1) ? $clog2(NUM) : 1
)(
   input  logic [NUM-1:0] s_valid,
   input  logic [GW-1:0]  last_grant,
   output logic [GW-1:0]  pick_idx,
   output logic           pick_vld
);

   logic [MAX_REQ-1:0] req_ext;

   // Zero-extend the request vector and rotate-search it from last_grant+1.
   always_comb begin
      req_ext          = '0;
      req_ext[NUM-1:0] = s_valid;
      pick_idx         = GW'(rr_next(req_ext, int'(last_grant), NUM));
      pick_vld         = |s_valid;
   end

endmodule

// File: rtl/data_inf_rr_arbiter.sv
// Round-robin arbiter with per-grant burst limit feeding one registered output slot.
// Latency: s_valid in IDLE -> s_ready next cycle -> beat on m_data the cycle after; one IDLE cycle per grant change.
// Backpressure: s_ready of the granted requester follows (!m_valid || m_ready); DATA_INF_RR_ARB_STAT_EN adds grant_cnt.
module data_inf_rr_arbiter
   import data_inf_arb_pkg::*;
#(
   parameter  int NUM   = 4,
   parameter  int DSIZE = 18,
   parameter  int BURST = 8,
   localparam int GW    = (NUM > 1) ? $clog2(NUM) : 1
)(
   input  logic                       clock,
   input  logic                       rst_n,
   input  logic [DSIZE-1:0]           s_data [NUM-1:0],
   input  logic [NUM-1:0]             s_valid,
   output logic [NUM-1:0]             s_ready,
   output logic [DSIZE-1:0]           m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [GW-1:0]              curr_grant,
   output logic                       busy
`ifdef DATA_INF_RR_ARB_STAT_EN
   ,
   output logic [NUM-1:0][STAT_W-1:0] grant_cnt
`endif
);

   localparam int BW = $clog2(BURST + 1);

   arb_state_e       state_q, state_d;
   logic [GW-1:0]    last_grant_q, last_grant_d;
   logic [GW-1:0]    curr_grant_q, curr_grant_d;
   logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
   logic             m_valid_q, m_valid_d;
   logic [DSIZE-1:0] m_data_q, m_data_d;

   logic [GW-1:0]    pick_idx;
   logic             pick_vld;
   logic             slot_free;
   logic             grant_vld;
   logic             accept;

   data_inf_rr_pick #(.NUM(NUM)) u_pick (
      .s_valid    (s_valid),
      .last_grant (last_grant_q),
      .pick_idx   (pick_idx),
      .pick_vld   (pick_vld)
   );

   // Only the granted requester sees ready, and only when the output slot can take a beat.
   always_comb begin
      slot_free = !m_valid_q || m_ready;
      grant_vld = s_valid[curr_grant_q];
      s_ready   = '0;
      if (state_q == GRANT) begin
         s_ready[curr_grant_q] = slot_free;
      end
      accept = (state_q == GRANT) && slot_free && grant_vld;
   end

   // Arbitration FSM: pick in IDLE, release on full burst or on an idle requester that could have sent.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      curr_grant_d = curr_grant_q;
      beat_cnt_d   = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d      = GRANT;
               curr_grant_d = pick_idx;
               last_grant_d = pick_idx;
               beat_cnt_d   = '0;
            end
         end
         GRANT: begin
            if (accept) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == BW'(BURST - 1)) begin
                  state_d = IDLE;
               end
            end else if (slot_free && !grant_vld) begin
               // A stalled output never releases here: slot_free is low then.
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output slot: load on accept, otherwise empty it once the sink takes the beat.
   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      if (accept) begin
         m_valid_d = 1'b1;
         m_data_d  = s_data[curr_grant_q];
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   // State and datapath registers; last_grant starts at NUM-1 so requester 0 wins first.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= GW'(NUM - 1);
         curr_grant_q <= '0;
         beat_cnt_q   <= '0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         curr_grant_q <= curr_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
      end
   end

   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign curr_grant = curr_grant_q;
   assign busy       = (state_q == GRANT);

`ifdef DATA_INF_RR_ARB_STAT_EN
   logic [NUM-1:0][STAT_W-1:0] grant_cnt_q, grant_cnt_d;

   // Count each new grant against the requester that won it; wraps naturally.
   always_comb begin
      grant_cnt_d = grant_cnt_q;
      if ((state_q == IDLE) && pick_vld) begin
         grant_cnt_d[pick_idx] = grant_cnt_q[pick_idx] + 1'b1;
      end
   end

   // Statistics registers.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt_q <= '0;
      end else begin
         grant_cnt_q <= grant_cnt_d;
      end
   end

   assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_data_inf_rr_arbiter.sv
// Bench for data_inf_rr_arbiter: two instances (BURST=8 and BURST=2) share stimulus.
// Latency: a queue-based model predicts every output each cycle.
// Backpressure: m_ready is driven directly, both directed and random.
module tb_data_inf_rr_arbiter;

   localparam int NUM   = 4;
   localparam int DSIZE = 18;

   logic clock = 1'b0;
   logic rst_n;
   logic m_ready;

   logic [3:0]       sv_a, sv_b, sr_a, sr_b;
   logic [DSIZE-1:0] sd_a [3:0];
   logic [DSIZE-1:0] sd_b [3:0];
   logic [DSIZE-1:0] md_a, md_b;
   logic             mv_a, mv_b, bz_a, bz_b;
   logic [1:0]       cg_a, cg_b;
`ifdef DATA_INF_RR_ARB_STAT_EN
   logic [3:0][15:0] gc_a, gc_b;
`endif

   always #5 clock = ~clock;

   data_inf_rr_arbiter #(.NUM(NUM), .DSIZE(DSIZE), .BURST(8)) dut_a (
      .clock (clock), .rst_n (rst_n),
      .s_data (sd_a), .s_valid (sv_a), .s_ready (sr_a),
      .m_data (md_a), .m_valid (mv_a), .m_ready (m_ready),
      .curr_grant (cg_a), .busy (bz_a)
`ifdef DATA_INF_RR_ARB_STAT_EN
      , .grant_cnt (gc_a)
`endif
   );

   data_inf_rr_arbiter #(.NUM(NUM), .DSIZE(DSIZE), .BURST(2)) dut_b (
      .clock (clock), .rst_n (rst_n),
      .s_data (sd_b), .s_valid (sv_b), .s_ready (sr_b),
      .m_data (md_b), .m_valid (mv_b), .m_ready (m_ready),
      .curr_grant (cg_b), .busy (bz_b)
`ifdef DATA_INF_RR_ARB_STAT_EN
      , .grant_cnt (gc_b)
`endif
   );

   // Reference model: per-instance source queues, output slot as a queue,
   // current owner (-1 = arbitrating), beats taken in this grant.
   logic [DSIZE-1:0] src  [2][4][$];
   logic [DSIZE-1:0] outq [2][$];
   logic [DSIZE-1:0] rx   [2][$];
   int               gseq [2][$];
   int               owner [2], last [2], curr [2], beats [2];
   int               gcnt [2][4];
   logic             prev_busy [2];
   logic [3:0]       en;
   int               vectors = 0;
   int               miscompares = 0;

   function automatic int burst_of(input int d);
      return (d == 0) ? 8 : 2;
   endfunction

   task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
      end
   endtask

   task automatic observe(input int d, output logic mv, output logic [DSIZE-1:0] md,
                          output logic [3:0] sr, output logic bz, output logic [1:0] cg);
      mv = (d == 0) ? mv_a : mv_b;
      md = (d == 0) ? md_a : md_b;
      sr = (d == 0) ? sr_a : sr_b;
      bz = (d == 0) ? bz_a : bz_b;
      cg = (d == 0) ? cg_a : cg_b;
   endtask

   function automatic logic [3:0] exp_ready(input int d);
      logic [3:0] r;
      r = '0;
      if (owner[d] >= 0 && (outq[d].size() == 0 || m_ready)) r[owner[d]] = 1'b1;
      return r;
   endfunction

   function automatic bit model_quiet();
      bit q;
      q = 1'b1;
      for (int d = 0; d < 2; d++) begin
         if (owner[d] >= 0 || outq[d].size() != 0) q = 1'b0;
         for (int i = 0; i < 4; i++) if (src[d][i].size() != 0) q = 1'b0;
      end
      return q;
   endfunction

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         sv_a[i] = en[i] && (src[0][i].size() > 0);
         sd_a[i] = (src[0][i].size() > 0) ? src[0][i][0] : '0;
         sv_b[i] = en[i] && (src[1][i].size() > 0);
         sd_b[i] = (src[1][i].size() > 0) ? src[1][i][0] : '0;
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         owner[d] = -1; last[d] = NUM - 1; curr[d] = 0; beats[d] = 0;
         outq[d].delete();
         prev_busy[d] = 1'b0;
         for (int i = 0; i < 4; i++) gcnt[d][i] = 0;
      end
   endtask

   task automatic clear_logs();
      for (int d = 0; d < 2; d++) begin
         rx[d].delete();
         gseq[d].delete();
      end
   endtask

   // One clock cycle: drive, sample mid-cycle, compare, advance the model across the edge.
   task automatic step();
      logic             mv, bz, acc;
      logic [DSIZE-1:0] md;
      logic [3:0]       sr, er, v;
      logic [1:0]       cg;
      int               o;
      drive();
      #3;
      for (int d = 0; d < 2; d++) begin
         observe(d, mv, md, sr, bz, cg);
         er = exp_ready(d);
         check("m_valid", d, mv, outq[d].size() > 0);
         if (outq[d].size() > 0) check("m_data", d, md, outq[d][0]);
         check("s_ready", d, sr, er);
         check("busy", d, bz, owner[d] >= 0);
         check("curr_grant", d, cg, curr[d]);
`ifdef DATA_INF_RR_ARB_STAT_EN
         for (int i = 0; i < 4; i++)
            check("grant_cnt", d, (d == 0) ? gc_a[i] : gc_b[i], gcnt[d][i] & 16'hFFFF);
`endif
         if (mv && m_ready) rx[d].push_back(md);
         if (bz && !prev_busy[d]) gseq[d].push_back(int'(cg));
         prev_busy[d] = bz;

         v   = (d == 0) ? sv_a : sv_b;
         o   = owner[d];
         acc = (o >= 0) && er[o] && v[o];
         if (outq[d].size() > 0 && m_ready) void'(outq[d].pop_front());
         if (acc) outq[d].push_back(src[d][o].pop_front());
         if (o < 0) begin
            for (int k = 1; k <= NUM; k++)
               if (owner[d] < 0 && v[(last[d] + k) % NUM]) owner[d] = (last[d] + k) % NUM;
            if (owner[d] >= 0) begin
               last[d] = owner[d]; curr[d] = owner[d]; beats[d] = 0;
               gcnt[d][owner[d]]++;
            end
         end else if (acc) begin
            beats[d]++;
            if (beats[d] == burst_of(d)) owner[d] = -1;
         end else if (er[o] && !v[o]) begin
            owner[d] = -1;
         end
      end
      @(posedge clock);
      #1;
   endtask

   // Asynchronous reset taken mid-cycle; outputs must clear before any edge.
   task automatic do_reset();
      logic             mv, bz;
      logic [DSIZE-1:0] md;
      logic [3:0]       sr;
      logic [1:0]       cg;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         observe(d, mv, md, sr, bz, cg);
         check("rst_m_valid", d, mv, 0);
         check("rst_m_data", d, md, 0);
         check("rst_s_ready", d, sr, 0);
         check("rst_busy", d, bz, 0);
         check("rst_curr_grant", d, cg, 0);
      end
      model_reset();
      @(posedge clock);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic run_drain(input int budget);
      int n;
      n = 0;
      while (!model_quiet() && n < budget) begin
         step();
         n++;
      end
      check("drain_within_budget", 0, model_quiet(), 1);
   endtask

   initial begin
      en      = '0;
      m_ready = 1'b1;
      model_reset();
      drive();
      do_reset();

      // Single requester 2, data 0x10..0x1F.
      clear_logs();
      for (int k = 0; k < 16; k++) begin
         src[0][2].push_back(18'h10 + 18'(k));
         src[1][2].push_back(18'h10 + 18'(k));
      end
      en = 4'b0100;
      run_drain(80);
      for (int d = 0; d < 2; d++) begin
         check("single_count", d, rx[d].size(), 16);
         for (int k = 0; k < 16 && k < rx[d].size(); k++) check("single_order", d, rx[d][k], 18'h10 + 18'(k));
      end
      check("single_grants_a", 0, gseq[0].size(), 2);
      check("single_grants_b", 1, gseq[1].size(), 8);

      // Fairness: all four continuously valid, four beats each.
      do_reset();
      clear_logs();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) begin
            src[0][i].push_back(18'h100 + 18'(i * 16 + k));
            src[1][i].push_back(18'h100 + 18'(i * 16 + k));
         end
      en = 4'b1111;
      run_drain(80);
      check("fair_grants_b", 1, gseq[1].size(), 8);
      for (int j = 0; j < 5 && j < gseq[1].size(); j++) check("fair_seq_b", 1, gseq[1][j], j % 4);
      check("fair_count_a", 0, rx[0].size(), 16);
      check("fair_count_b", 1, rx[1].size(), 16);
      for (int k = 0; k < 16 && k < rx[0].size(); k++)
         check("fair_order_a", 0, rx[0][k], 18'h100 + 18'((k / 4) * 16 + (k % 4)));
      for (int k = 0; k < 16 && k < rx[1].size(); k++)
         check("fair_order_b", 1, rx[1][k], 18'h100 + 18'(((k / 2) % 4) * 16 + 2 * (k / 8) + (k % 2)));
`ifdef DATA_INF_RR_ARB_STAT_EN
      for (int i = 0; i < 4; i++) check("stat_fair_b", 1, gc_b[i], 2);
`endif

      // Backpressure: stall five cycles mid-burst, with s_valid dropping inside the stall.
      clear_logs();
      for (int k = 0; k < 8; k++) begin
         src[0][1].push_back(18'h200 + 18'(k));
         src[1][1].push_back(18'h200 + 18'(k));
      end
      en = 4'b0010;
      m_ready = 1'b1;
      repeat (3) step();
      m_ready = 1'b0;
      step();
      step();
      en = 4'b0000;
      step();
      step();
      en = 4'b0010;
      step();
      m_ready = 1'b1;
      run_drain(60);
      for (int d = 0; d < 2; d++) begin
         check("bp_count", d, rx[d].size(), 8);
         for (int k = 0; k < 8 && k < rx[d].size(); k++) check("bp_order", d, rx[d][k], 18'h200 + 18'(k));
      end

      // Early release: requester 1 has three beats, requester 3 is waiting.
      do_reset();
      clear_logs();
      for (int k = 0; k < 3; k++) begin
         src[0][1].push_back(18'h300 + 18'(k));
         src[1][1].push_back(18'h300 + 18'(k));
      end
      for (int k = 0; k < 4; k++) begin
         src[0][3].push_back(18'h330 + 18'(k));
         src[1][3].push_back(18'h330 + 18'(k));
      end
      en = 4'b1010;
      run_drain(60);
      check("early_grants_a", 0, gseq[0].size(), 2);
      if (gseq[0].size() == 2) begin
         check("early_first_a", 0, gseq[0][0], 1);
         check("early_second_a", 0, gseq[0][1], 3);
      end

      // Reset with a beat held in the output register.
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 10; k++) begin
            src[0][i].push_back(18'h400 + 18'(i * 16 + k));
            src[1][i].push_back(18'h400 + 18'(i * 16 + k));
         end
      en = 4'b1111;
      m_ready = 1'b1;
      repeat (3) step();
      m_ready = 1'b0;
      step();
      check("pre_reset_m_valid", 0, mv_a, 1);
      do_reset();
      clear_logs();
      m_ready = 1'b1;
      repeat (3) step();
      for (int d = 0; d < 2; d++) begin
         check("post_reset_grants", d, gseq[d].size() >= 1, 1);
         if (gseq[d].size() >= 1) check("post_reset_first", d, gseq[d][0], 0);
      end
      run_drain(200);

      // Random traffic and backpressure.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++)
            if (src[0][i].size() < 6 && $urandom_range(0, 2) == 0) begin
               logic [DSIZE-1:0] x;
               x = DSIZE'($urandom);
               src[0][i].push_back(x);
               src[1][i].push_back(x);
            end
         en      = 4'($urandom);
         m_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      en      = 4'b1111;
      m_ready = 1'b1;
      run_drain(300);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
